// File: rtl/poolb_ctrl_pkg.sv
// poolb_ctrl_pkg: shared state encoding and size helpers for the
// three-unit pooling controller.
package poolb_ctrl_pkg;

   localparam int UNITS = 3;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_ROW,
      STREAM,
      DRAIN,
      DONE
   } state_t;

   // Never returns less than 1 so every counter keeps at least one bit.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int ofm_size(input int ifm, input int k);
      return ifm / k;
   endfunction

   function automatic int num_groups(input int depth);
      return (depth + UNITS - 1) / UNITS;
   endfunction

   function automatic logic [UNITS-1:0] last_mask(input int depth);
      int n;
      n = depth - UNITS * (num_groups(depth) - 1);
      return UNITS'((1 << n) - 1);
   endfunction

endpackage

// File: rtl/poolb_ctrl_u3_delay.sv
// poolb_ctrl_delay: fixed-depth shift register with asynchronous clear,
// used to align enables and write fields with memory/pool latency.
module poolb_ctrl_delay #(
   parameter int W = 1,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] sr [D];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < D; i++) sr[i] <= '0;
      end else begin
         sr[0] <= d;
         for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
      end
   end

   assign q = sr[D-1];

endmodule

// File: rtl/poolb_ctrl_u3.sv
// poolb_ctrl_u3: row/column sequencer for the three-unit 2x2 pooling
// datapath; issues paired IFM reads and times fifo/pool/OFM writes.
module poolb_ctrl_u3
   import poolb_ctrl_pkg::*;
#(
   parameter int IFM_SIZE = 10,
   parameter int IFM_DEPTH = 16,
   parameter int KERNAL_SIZE = 2,
   parameter int RD_LATENCY = 1,
   parameter int POOL_LATENCY = 1,
   localparam int OFM_SIZE = ofm_size(IFM_SIZE, KERNAL_SIZE),
   localparam int NUM_GROUPS = num_groups(IFM_DEPTH),
   localparam int RA_W = clog2(NUM_GROUPS * IFM_SIZE * IFM_SIZE),
   localparam int WA_W = clog2(NUM_GROUPS * OFM_SIZE * OFM_SIZE)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            ofm_ready,
   output logic            busy,
   output logic            done,
   output logic [RA_W-1:0] rd_addr_A,
   output logic [RA_W-1:0] rd_addr_B,
   output logic            rd_en,
   output logic            fifo_enable,
   output logic            pool_enable,
   output logic            wr_en,
   output logic [WA_W-1:0] wr_addr,
   output logic [2:0]      unit_mask
);

   localparam int CW = clog2(IFM_SIZE);
   localparam int RW = clog2(OFM_SIZE);
   localparam int GW = clog2(NUM_GROUPS);
   localparam int DRAIN_CYC = RD_LATENCY + POOL_LATENCY;
   localparam int DW = clog2(DRAIN_CYC);
   localparam int P1W = WA_W + 5;
   localparam int P2W = WA_W + 4;
   localparam logic [CW-1:0] C_LAST = CW'(IFM_SIZE - 1);
   localparam logic [RW-1:0] R_LAST = RW'(OFM_SIZE - 1);
   localparam logic [GW-1:0] G_LAST = GW'(NUM_GROUPS - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYC - 1);
   localparam logic [RA_W-1:0] RD_STEP = RA_W'(KERNAL_SIZE * IFM_SIZE);
   localparam logic [RA_W-1:0] B_OFS = RA_W'(IFM_SIZE);
   localparam logic [WA_W-1:0] WR_STEP = WA_W'(OFM_SIZE);
   localparam logic [2:0] LAST_MASK = last_mask(IFM_DEPTH);

   state_t state, state_nx;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [GW-1:0] grp;
   logic [DW-1:0] dcnt;
   logic [RA_W-1:0] rd_base, ra;
   logic [WA_W-1:0] wr_base;
   logic stream, row_end, layer_end;

   assign stream = (state == STREAM);
   assign row_end = stream && (col == C_LAST);
   assign layer_end = row_end && (row == R_LAST) && (grp == G_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy = 1'b1;
      done = 1'b0;
      rd_en = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nx = WAIT_ROW;
         end
         WAIT_ROW: if (ofm_ready) state_nx = STREAM;
         STREAM: begin
            rd_en = 1'b1;
            if (layer_end) state_nx = DRAIN;
            else if (row_end) state_nx = WAIT_ROW;
         end
         DRAIN: if (dcnt == D_LAST) state_nx = DONE;
         DONE: begin
            done = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Groups are contiguous, so row bases advance by a fixed step
   // across group boundaries too.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col <= '0;
         row <= '0;
         grp <= '0;
         dcnt <= '0;
         rd_base <= '0;
         wr_base <= '0;
      end else begin
         if (layer_end) begin
            col <= '0;
            row <= '0;
            grp <= '0;
            rd_base <= '0;
            wr_base <= '0;
         end else if (row_end) begin
            col <= '0;
            rd_base <= rd_base + RD_STEP;
            wr_base <= wr_base + WR_STEP;
            if (row == R_LAST) begin
               row <= '0;
               grp <= grp + 1'b1;
            end else begin
               row <= row + 1'b1;
            end
         end else if (stream) begin
            col <= col + 1'b1;
         end
         dcnt <= (state == DRAIN) ? dcnt + 1'b1 : '0;
      end
   end

   assign ra = rd_base + RA_W'(col);
   assign rd_addr_A = rd_en ? ra : '0;
   assign rd_addr_B = rd_en ? ra + B_OFS : '0;

   logic [P1W-1:0] p1_d, p1_q;
   logic [P2W-1:0] p2_d, p2_q;
   logic [WA_W-1:0] wa0, wa1, wa2;
   logic [2:0] m0, m1, m2;
   logic rd_q, odd_q, wr_q;

   assign wa0 = wr_base + WA_W'(col >> 1);
   assign m0 = (grp == G_LAST) ? LAST_MASK : 3'b111;
   assign p1_d = {rd_en, rd_en & col[0], wa0, m0};
   assign {rd_q, odd_q, wa1, m1} = p1_q;
   assign p2_d = {odd_q, wa1, m1};
   assign {wr_q, wa2, m2} = p2_q;

   poolb_ctrl_delay #(.W(P1W), .D(RD_LATENCY)) u_rd_dly (
      .clk(clk),
      .reset(reset),
      .d(p1_d),
      .q(p1_q)
   );

   poolb_ctrl_delay #(.W(P2W), .D(POOL_LATENCY)) u_pool_dly (
      .clk(clk),
      .reset(reset),
      .d(p2_d),
      .q(p2_q)
   );

   assign fifo_enable = rd_q;
   assign pool_enable = odd_q;
   assign wr_en = wr_q;
   assign wr_addr = wr_q ? wa2 : '0;
   assign unit_mask = wr_q ? m2 : '0;

endmodule

// File: tb/tb_poolb_ctrl_u3.sv
// tb_poolb_ctrl_u3: directed bench with a row-schedule model for three
// configurations: default, 18 channels, read/pool latency 2/3.
module tb_poolb_ctrl_u3;

   localparam int NC = 400;
   localparam int ND = 3;

   logic clk = 1'b0;
   logic rst_n, start, ofm_ready;
   logic busy_o [ND];
   logic done_o [ND];
   logic rd_o [ND];
   logic fifo_o [ND];
   logic pool_o [ND];
   logic wr_o [ND];
   logic [9:0] ra_o [ND];
   logic [9:0] rb_o [ND];
   logic [7:0] wa_o [ND];
   logic [2:0] um_o [ND];

   always #5 clk = ~clk;

   poolb_ctrl_u3 dut0 (
      .clk(clk), .reset(rst_n), .start(start), .ofm_ready(ofm_ready),
      .busy(busy_o[0]), .done(done_o[0]),
      .rd_addr_A(ra_o[0]), .rd_addr_B(rb_o[0]), .rd_en(rd_o[0]),
      .fifo_enable(fifo_o[0]), .pool_enable(pool_o[0]),
      .wr_en(wr_o[0]), .wr_addr(wa_o[0]), .unit_mask(um_o[0])
   );

   poolb_ctrl_u3 #(.IFM_DEPTH(18)) dut1 (
      .clk(clk), .reset(rst_n), .start(start), .ofm_ready(ofm_ready),
      .busy(busy_o[1]), .done(done_o[1]),
      .rd_addr_A(ra_o[1]), .rd_addr_B(rb_o[1]), .rd_en(rd_o[1]),
      .fifo_enable(fifo_o[1]), .pool_enable(pool_o[1]),
      .wr_en(wr_o[1]), .wr_addr(wa_o[1]), .unit_mask(um_o[1])
   );

   poolb_ctrl_u3 #(.RD_LATENCY(2), .POOL_LATENCY(3)) dut2 (
      .clk(clk), .reset(rst_n), .start(start), .ofm_ready(ofm_ready),
      .busy(busy_o[2]), .done(done_o[2]),
      .rd_addr_A(ra_o[2]), .rd_addr_B(rb_o[2]), .rd_en(rd_o[2]),
      .fifo_enable(fifo_o[2]), .pool_enable(pool_o[2]),
      .wr_en(wr_o[2]), .wr_addr(wa_o[2]), .unit_mask(um_o[2])
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Expected outputs per cycle, derived from the row schedule.
   bit e_busy [ND][NC];
   bit e_done [ND][NC];
   bit e_rd [ND][NC];
   bit e_fifo [ND][NC];
   bit e_pool [ND][NC];
   bit e_wr [ND][NC];
   int e_a [ND][NC];
   int e_wa [ND][NC];
   int e_m [ND][NC];

   task automatic build(input int k, input int rdl, input int pl,
                        input int depth, input int slo, input int slen);
      int t, ng, cy, dc, n;
      for (int i = 0; i < NC; i++) begin
         e_busy[k][i] = 0; e_done[k][i] = 0; e_rd[k][i] = 0;
         e_fifo[k][i] = 0; e_pool[k][i] = 0; e_wr[k][i] = 0;
         e_a[k][i] = 0; e_wa[k][i] = 0; e_m[k][i] = 0;
      end
      ng = (depth + 2) / 3;
      t = 1;
      for (int g = 0; g < ng; g++) begin
         for (int r = 0; r < 5; r++) begin
            while (t >= slo && t < slo + slen) t++;
            for (int c = 0; c < 10; c++) begin
               cy = t + 1 + c;
               e_rd[k][cy] = 1;
               e_a[k][cy] = g * 100 + 2 * r * 10 + c;
               e_fifo[k][cy + rdl] = 1;
               if (c % 2 == 1) begin
                  n = depth - 3 * g;
                  e_pool[k][cy + rdl] = 1;
                  e_wr[k][cy + rdl + pl] = 1;
                  e_wa[k][cy + rdl + pl] = g * 25 + r * 5 + c / 2;
                  e_m[k][cy + rdl + pl] = (n >= 3) ? 7 : (1 << n) - 1;
               end
            end
            t += 11;
         end
      end
      dc = (t - 1) + rdl + pl + 1;
      for (int i = 1; i <= dc; i++) e_busy[k][i] = 1;
      e_done[k][dc] = 1;
   endtask

   int rel = 0;
   bit active = 0;
   int slo = 0;
   int slen = 0;
   bit pulses = 0;

   int rd_cnt [ND];
   int fifo_cnt [ND];
   int pool_cnt [ND];
   int wr_cnt [ND];
   int busy_cnt [ND];
   int done_at [ND];
   int m1_cnt [ND];
   int m7_cnt [ND];
   int first_wr, first_wa, stall_rd;
   logic [9:0] a2, b2, a86, b86;
   logic [7:0] wa88;
   logic p34, w35;
   logic [36:0] ev, av;

   function automatic logic [36:0] pack_all(input int k);
      return {busy_o[k], done_o[k], rd_o[k], ra_o[k], rb_o[k],
              fifo_o[k], pool_o[k], wr_o[k], wa_o[k], um_o[k]};
   endfunction

   always @(negedge clk) begin
      if (active && rel >= 0 && rel < NC) begin
         for (int k = 0; k < ND; k++) begin
            ev = {e_busy[k][rel], e_done[k][rel], e_rd[k][rel],
                  10'(e_rd[k][rel] ? e_a[k][rel] : 0),
                  10'(e_rd[k][rel] ? e_a[k][rel] + 10 : 0),
                  e_fifo[k][rel], e_pool[k][rel], e_wr[k][rel],
                  8'(e_wr[k][rel] ? e_wa[k][rel] : 0),
                  3'(e_wr[k][rel] ? e_m[k][rel] : 0)};
            av = {busy_o[k], done_o[k], rd_o[k],
                  e_rd[k][rel] ? ra_o[k] : 10'd0,
                  e_rd[k][rel] ? rb_o[k] : 10'd0,
                  fifo_o[k], pool_o[k], wr_o[k],
                  e_wr[k][rel] ? wa_o[k] : 8'd0,
                  e_wr[k][rel] ? um_o[k] : 3'd0};
            chk($sformatf("dut%0d cycle %0d", k, rel), av, ev);
            rd_cnt[k] += int'(rd_o[k]);
            fifo_cnt[k] += int'(fifo_o[k]);
            pool_cnt[k] += int'(pool_o[k]);
            wr_cnt[k] += int'(wr_o[k]);
            busy_cnt[k] += int'(busy_o[k]);
            if (done_o[k] && done_at[k] < 0) done_at[k] = rel;
            if (wr_o[k] && um_o[k] == 3'b001) m1_cnt[k]++;
            if (wr_o[k] && um_o[k] == 3'b111) m7_cnt[k]++;
         end
         if (rel == 2) begin a2 = ra_o[0]; b2 = rb_o[0]; end
         if (rel == 86) begin a86 = ra_o[0]; b86 = rb_o[0]; end
         if (rel == 88) wa88 = wa_o[0];
         if (rel == 34) p34 = pool_o[0];
         if (rel == 35) w35 = wr_o[0];
         if (rel >= 34 && rel <= 41) stall_rd += int'(rd_o[0]);
         if (wr_o[0] && first_wr < 0) begin
            first_wr = rel;
            first_wa = int'(wa_o[0]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      rel++;
      #1;
      ofm_ready = !(rel >= slo && rel < slo + slen);
      start = pulses && (rel == 50 || rel == 333);
   endtask

   task automatic run_to(input int n);
      while (rel < n) tick();
   endtask

   // Called just after an edge; start is high in cycle 0.
   task automatic launch();
      for (int k = 0; k < ND; k++) begin
         build(k, (k == 2) ? 2 : 1, (k == 2) ? 3 : 1,
               (k == 1) ? 18 : 16, slo, slen);
         rd_cnt[k] = 0; fifo_cnt[k] = 0; pool_cnt[k] = 0;
         wr_cnt[k] = 0; busy_cnt[k] = 0; done_at[k] = -1;
         m1_cnt[k] = 0; m7_cnt[k] = 0;
      end
      first_wr = -1; first_wa = -1; stall_rd = 0;
      rel = 0;
      start = 1'b1;
      ofm_ready = 1'b1;
      active = 1'b1;
      tick();
   endtask

   logic seen [ND];

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      ofm_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < ND; k++)
         chk($sformatf("reset outputs dut%0d", k), pack_all(k), 0);
      rst_n = 1'b1;
      tick();
      tick();

      pulses = 1'b1;
      launch();
      run_to(360);
      active = 1'b0;
      pulses = 1'b0;
      chk("rd_en count", rd_cnt[0], 300);
      chk("fifo_enable count", fifo_cnt[0], 300);
      chk("pool_enable count", pool_cnt[0], 150);
      chk("wr_en count", wr_cnt[0], 150);
      chk("busy cycles", busy_cnt[0], 333);
      chk("done cycle dut0", done_at[0], 333);
      chk("done cycle depth18", done_at[1], 333);
      chk("done cycle lat2/3", done_at[2], 336);
      chk("first rd_addr_A", a2, 0);
      chk("first rd_addr_B", b2, 10);
      chk("first wr cycle", first_wr, 5);
      chk("first wr_addr", first_wa, 0);
      chk("g1 r2 c7 rd_addr_A", a86, 147);
      chk("g1 r2 c7 rd_addr_B", b86, 157);
      chk("g1 r2 c7 wr_addr", wa88, 38);
      chk("last group mask 001 writes", m1_cnt[0], 25);
      chk("mask 111 writes", m7_cnt[0], 125);
      chk("depth18 mask 111 writes", m7_cnt[1], 150);

      slo = 34;
      slen = 7;
      launch();
      run_to(360);
      active = 1'b0;
      chk("stall done cycle", done_at[0], 340);
      chk("stall done lat2/3", done_at[2], 343);
      chk("stall rd_en during stall", stall_rd, 0);
      chk("row2 pool_enable in stall", p34, 1);
      chk("row2 wr_en in stall", w35, 1);
      chk("stall rd_en count", rd_cnt[0], 300);

      slo = 0;
      slen = 0;
      launch();
      run_to(150);
      active = 1'b0;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < ND; k++)
         chk($sformatf("mid-layer reset dut%0d", k), pack_all(k), 0);
      tick();
      tick();
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < ND; k++) seen[k] = 1'b0;
      repeat (20) begin
         tick();
         for (int k = 0; k < ND; k++)
            seen[k] = seen[k] | busy_o[k] | done_o[k];
      end
      for (int k = 0; k < ND; k++)
         chk($sformatf("idle after reset dut%0d", k), seen[k], 0);

      launch();
      run_to(360);
      active = 1'b0;
      chk("rerun first rd_addr_A", a2, 0);
      chk("rerun first rd_addr_B", b2, 10);
      chk("rerun done cycle", done_at[0], 333);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
